// File: rtl/global_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : global_buffer_pkg
// Description : Shared address/data geometry and packet types for the global
//               buffer core: write, read-request and read-response packets.
// Revision    : 1.0 - initial release
// ============================================================================
package global_buffer_pkg;

  // Address map: {tile_sel, bank_sel, bank_addr}
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int BANK_STRB_WIDTH     = BANK_DATA_WIDTH / 8;
  localparam int BANK_ADDR_WIDTH     = 17;
  localparam int BANK_SEL_ADDR_WIDTH = 1;
  localparam int TILE_SEL_ADDR_WIDTH = 5;
  localparam int GLB_ADDR_WIDTH      = TILE_SEL_ADDR_WIDTH + BANK_SEL_ADDR_WIDTH
                                     + BANK_ADDR_WIDTH;

  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic [BANK_DATA_WIDTH-1:0] rd_data;
    logic                       rd_data_valid;
  } rdrs_packet_t;

endpackage
`default_nettype wire

// File: rtl/glb_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : glb_rd_tracker
// Description : Fixed-latency read tracker. Each issued read enters a shift
//               register of {valid, bank_sel}; the last stage (head) marks the
//               cycle the bank response is due. Also counts reads in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_rd_tracker #(
  parameter int DEPTH     = 3,
  parameter int SEL_WIDTH = 1,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic [SEL_WIDTH-1:0] bank_sel,
  output logic                 head_valid,
  output logic [SEL_WIDTH-1:0] head_bank_sel,
  output logic [CNT_WIDTH-1:0] count
);

  logic [DEPTH-1:0]     r_valid;
  logic [SEL_WIDTH-1:0] r_sel [DEPTH];
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_next;

  // Shift every cycle; a new read always enters stage 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_sel[i] <= '0;
    end else begin
      r_valid[0] <= issue;
      r_sel[0]   <= bank_sel;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_sel[i]   <= r_sel[i-1];
      end
    end
  end

  // Issue and retire in the same cycle cancel out.
  always_comb begin
    w_count_next = r_count;
    case ({issue, head_valid})
      2'b10:   w_count_next = r_count + CNT_WIDTH'(1);
      2'b01:   w_count_next = r_count - CNT_WIDTH'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Outstanding-read counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_count <= '0;
    else       r_count <= w_count_next;
  end

  assign head_valid    = r_valid[DEPTH-1];
  assign head_bank_sel = r_sel[DEPTH-1];
  assign count         = r_count;

endmodule
`default_nettype wire

// File: rtl/glb_core_proc_bank_switch.sv
`default_nettype none
// ============================================================================
// Module      : glb_core_proc_bank_switch
// Description : Routes tile-filtered processor write/read requests to the
//               addressed bank (one register stage) and returns the matching
//               bank read response to the processor router, flagging any
//               response that does not line up with an issued read.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_core_proc_bank_switch
  import global_buffer_pkg::*;
#(
  parameter int BANKS_PER_TILE  = 2,
  parameter int BANK_RD_LATENCY = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  wr_packet_t                           wr_packet_pr2sw,
  input  rdrq_packet_t                         rdrq_packet_pr2sw,
  output rdrs_packet_t                         rdrs_packet_sw2pr,
  output wr_packet_t                           wr_packet_sw2b   [BANKS_PER_TILE],
  output rdrq_packet_t                         rdrq_packet_sw2b [BANKS_PER_TILE],
  input  rdrs_packet_t                         rdrs_packet_b2sw [BANKS_PER_TILE],
  output logic [$clog2(BANK_RD_LATENCY+3)-1:0] rd_outstanding,
  output logic                                 rdrs_err,
  input  logic                                 rdrs_err_clr
);

  localparam int c_cnt_width = $clog2(BANK_RD_LATENCY + 3);
  localparam int c_depth     = BANK_RD_LATENCY + 1;

  wr_packet_t                     r_wr;
  rdrq_packet_t                   r_rdrq;
  rdrs_packet_t                   r_rdrs;
  logic                           r_err;

  logic [BANK_SEL_ADDR_WIDTH-1:0] w_wr_sel;
  logic [BANK_SEL_ADDR_WIDTH-1:0] w_rd_sel;
  logic [BANK_SEL_ADDR_WIDTH-1:0] w_issue_sel;
  logic                           w_head_valid;
  logic [BANK_SEL_ADDR_WIDTH-1:0] w_head_sel;
  rdrs_packet_t                   w_head_rsp;
  logic                           w_hit;
  logic                           w_stray;
  logic                           w_mismatch;

  // Request stage: capture the incoming packets once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr   <= '0;
      r_rdrq <= '0;
    end else begin
      r_wr   <= wr_packet_pr2sw;
      r_rdrq <= rdrq_packet_pr2sw;
    end
  end

  // Bank select ignores the tile bits above it.
  assign w_wr_sel    = r_wr.wr_addr[BANK_ADDR_WIDTH +: BANK_SEL_ADDR_WIDTH];
  assign w_rd_sel    = r_rdrq.rd_addr[BANK_ADDR_WIDTH +: BANK_SEL_ADDR_WIDTH];
  assign w_issue_sel = rdrq_packet_pr2sw.rd_addr[BANK_ADDR_WIDTH +: BANK_SEL_ADDR_WIDTH];

  // Only the addressed bank sees the request; disabled packets go out as zero.
  for (genvar b = 0; b < BANKS_PER_TILE; b++) begin : g_bank_demux
    localparam logic [BANK_SEL_ADDR_WIDTH-1:0] c_bank_idx = BANK_SEL_ADDR_WIDTH'(b);
    assign wr_packet_sw2b[b]   = (r_wr.wr_en && (w_wr_sel == c_bank_idx)) ? r_wr : '0;
    assign rdrq_packet_sw2b[b] = (r_rdrq.rd_en && (w_rd_sel == c_bank_idx)) ? r_rdrq : '0;
  end

  // The tracker is fed from the unregistered request so that its first stage
  // lines up with the cycle the read is presented to the bank; the head then
  // lands exactly BANK_RD_LATENCY cycles later.
  glb_rd_tracker #(
    .DEPTH     (c_depth),
    .SEL_WIDTH (BANK_SEL_ADDR_WIDTH),
    .CNT_WIDTH (c_cnt_width)
  ) u_rd_tracker (
    .clk           (clk),
    .reset         (reset),
    .issue         (rdrq_packet_pr2sw.rd_en),
    .bank_sel      (w_issue_sel),
    .head_valid    (w_head_valid),
    .head_bank_sel (w_head_sel),
    .count         (rd_outstanding)
  );

  assign w_head_rsp = rdrs_packet_b2sw[w_head_sel];
  assign w_hit      = w_head_valid && w_head_rsp.rd_data_valid;

  // Any bank valid not claimed by a valid head entry is a stray response.
  always_comb begin
    w_stray = 1'b0;
    for (int b = 0; b < BANKS_PER_TILE; b++) begin
      if (rdrs_packet_b2sw[b].rd_data_valid &&
          !(w_head_valid && (w_head_sel == BANK_SEL_ADDR_WIDTH'(b))))
        w_stray = 1'b1;
    end
  end

  assign w_mismatch = (w_head_valid && !w_head_rsp.rd_data_valid) || w_stray;

  // Response register: forward only the expected bank's data, else zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdrs <= '0;
    end else if (w_hit) begin
      r_rdrs.rd_data       <= w_head_rsp.rd_data;
      r_rdrs.rd_data_valid <= 1'b1;
    end else begin
      r_rdrs <= '0;
    end
  end

  // Sticky error flag; a fresh mismatch takes priority over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_err <= 1'b0;
    else if (w_mismatch)   r_err <= 1'b1;
    else if (rdrs_err_clr) r_err <= 1'b0;
  end

  assign rdrs_packet_sw2pr = r_rdrs;
  assign rdrs_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_glb_core_proc_bank_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_glb_core_proc_bank_switch
// Description : Directed self-checking bench for glb_core_proc_bank_switch
//               with hand-computed expected values (BANK_RD_LATENCY = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_core_proc_bank_switch;
  import global_buffer_pkg::*;

  localparam int BANKS = 2;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(LAT + 3);

  logic         clk;
  logic         reset;
  wr_packet_t   wr_in;
  rdrq_packet_t rdrq_in;
  rdrs_packet_t rdrs_out;
  wr_packet_t   wr_b   [BANKS];
  rdrq_packet_t rdrq_b [BANKS];
  rdrs_packet_t rdrs_b [BANKS];
  logic [CW-1:0] outstanding;
  logic         err;
  logic         err_clr;

  int checks   = 0;
  int failures = 0;

  // Bank 0 / bank 1 addresses with non-zero tile bits that must be ignored.
  localparam logic [GLB_ADDR_WIDTH-1:0] A0 = {5'h02, 1'b0, 17'h00010};
  localparam logic [GLB_ADDR_WIDTH-1:0] A1 = {5'h01, 1'b1, 17'h00020};

  glb_core_proc_bank_switch #(
    .BANKS_PER_TILE  (BANKS),
    .BANK_RD_LATENCY (LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_packet_pr2sw   (wr_in),
    .rdrq_packet_pr2sw (rdrq_in),
    .rdrs_packet_sw2pr (rdrs_out),
    .wr_packet_sw2b    (wr_b),
    .rdrq_packet_sw2b  (rdrq_b),
    .rdrs_packet_b2sw  (rdrs_b),
    .rd_outstanding    (outstanding),
    .rdrs_err          (err),
    .rdrs_err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic wr_packet_t mk_wr(input logic [GLB_ADDR_WIDTH-1:0] a, input logic [63:0] d);
    wr_packet_t p;
    p.wr_en = 1'b1; p.wr_strb = 8'hFF; p.wr_addr = a; p.wr_data = d;
    return p;
  endfunction

  function automatic rdrq_packet_t mk_rd(input logic [GLB_ADDR_WIDTH-1:0] a);
    rdrq_packet_t p;
    p.rd_en = 1'b1; p.rd_addr = a;
    return p;
  endfunction

  function automatic rdrs_packet_t mk_rs(input logic [63:0] d);
    rdrs_packet_t p;
    p.rd_data = d; p.rd_data_valid = 1'b1;
    return p;
  endfunction

  // Advance one cycle; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rsp();
    rdrs_b[0] = '0;
    rdrs_b[1] = '0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_in   = '0;
    rdrq_in = '0;
    err_clr = 1'b0;
    clear_rsp();

    // Reset state
    tick();
    check_eq("rst_rdrs", rdrs_out, '0);
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wr_b1", wr_b[1], '0);
    reset = 1'b0;
    tick();

    // Write to bank 1 is forwarded only to bank 1
    wr_in = mk_wr(A1, 64'hDEAD);
    tick();
    check_eq("wr_b1", wr_b[1], mk_wr(A1, 64'hDEAD));
    check_eq("wr_b0_zero", wr_b[0], '0);
    check_eq("wr_rdrq_b0_zero", rdrq_b[0], '0);
    wr_in = '0;
    tick();
    check_eq("wr_dis_b1_zero", wr_b[1], '0);

    // Single read from bank 0 with latency LAT+2
    rdrq_in = mk_rd(A0);
    tick();
    check_eq("rd_rdrq_b0", rdrq_b[0], mk_rd(A0));
    check_eq("rd_rdrq_b1_zero", rdrq_b[1], '0);
    check_eq("rd_outst_1", outstanding, 1);
    rdrq_in = '0;
    tick();
    tick();
    check_eq("rd_not_early", rdrs_out, '0);
    rdrs_b[0] = mk_rs(64'h1234);
    tick();
    clear_rsp();
    check_eq("rd_data", rdrs_out, mk_rs(64'h1234));
    check_eq("rd_outst_0", outstanding, 0);
    check_eq("rd_err_0", err, 0);
    tick();
    check_eq("rd_after_zero", rdrs_out, '0);

    // Back-to-back reads bank0, bank1, bank0
    rdrq_in = mk_rd(A0);
    tick();
    check_eq("b2b_outst_1", outstanding, 1);
    rdrq_in = mk_rd(A1);
    tick();
    check_eq("b2b_outst_2", outstanding, 2);
    rdrq_in = mk_rd(A0);
    tick();
    check_eq("b2b_outst_3", outstanding, 3);
    rdrq_in = '0;
    rdrs_b[0] = mk_rs(64'hA1);
    tick();
    check_eq("b2b_rsp0", rdrs_out, mk_rs(64'hA1));
    check_eq("b2b_outst_hold", outstanding, 2);
    clear_rsp();
    rdrs_b[1] = mk_rs(64'hB2);
    tick();
    check_eq("b2b_rsp1", rdrs_out, mk_rs(64'hB2));
    clear_rsp();
    rdrs_b[0] = mk_rs(64'hC3);
    tick();
    check_eq("b2b_rsp2", rdrs_out, mk_rs(64'hC3));
    check_eq("b2b_outst_0", outstanding, 0);
    check_eq("b2b_err_0", err, 0);
    clear_rsp();

    // Withheld response sets the error flag and returns nothing
    rdrq_in = mk_rd(A1);
    tick();
    rdrq_in = '0;
    tick();
    tick();
    tick();
    check_eq("miss_err", err, 1);
    check_eq("miss_no_valid", rdrs_out, '0);
    check_eq("miss_outst_0", outstanding, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("miss_clr", err, 0);

    // Stray response; then clear colliding with a new stray keeps the flag
    rdrs_b[0] = mk_rs(64'h99);
    tick();
    check_eq("stray_err", err, 1);
    check_eq("stray_discard", rdrs_out, '0);
    err_clr = 1'b1;
    tick();
    check_eq("clr_vs_new_err", err, 1);
    clear_rsp();
    tick();
    err_clr = 1'b0;
    check_eq("clr_final", err, 0);

    // Reset with two reads in flight; late responses are strays
    rdrq_in = mk_rd(A0);
    tick();
    rdrq_in = mk_rd(A1);
    tick();
    rdrq_in = '0;
    check_eq("inflight_outst_2", outstanding, 2);
    reset = 1'b1;
    #1;
    check_eq("async_outst", outstanding, 0);
    check_eq("async_rdrq_b1", rdrq_b[1], '0);
    check_eq("async_rdrs", rdrs_out, '0);
    check_eq("async_err", err, 0);
    tick();
    reset = 1'b0;
    rdrs_b[0] = mk_rs(64'h55);
    tick();
    check_eq("late0_err", err, 1);
    check_eq("late0_discard", rdrs_out, '0);
    clear_rsp();
    rdrs_b[1] = mk_rs(64'h66);
    tick();
    check_eq("late1_discard", rdrs_out, '0);
    clear_rsp();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("late_clr", err, 0);

    // Same-cycle write to bank 1 and read from bank 0
    wr_in   = mk_wr(A1, 64'hCAFE);
    rdrq_in = mk_rd(A0);
    tick();
    check_eq("mix_wr_b1", wr_b[1], mk_wr(A1, 64'hCAFE));
    check_eq("mix_wr_b0", wr_b[0], '0);
    check_eq("mix_rd_b0", rdrq_b[0], mk_rd(A0));
    check_eq("mix_rd_b1", rdrq_b[1], '0);
    wr_in   = '0;
    rdrq_in = '0;
    tick();
    tick();
    rdrs_b[0] = mk_rs(64'h5678);
    tick();
    clear_rsp();
    check_eq("mix_rsp", rdrs_out, mk_rs(64'h5678));
    check_eq("mix_outst_0", outstanding, 0);
    check_eq("mix_err_0", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
